// File: rtl/wb_slave_mem_if.sv
// Wishbone classic single-transfer bus between one master and the memory slave.
// Carries the handshake, address, data and termination signals.
interface wb_slave_mem_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_slave_mem.sv
// Wishbone word memory with byte lanes; ack/err 1+WAIT_CYCLES cycles after acceptance.
// No new request is taken until the single-cycle response has completed; dropping cyc in WAIT aborts.
module wb_slave_mem #(
    parameter int          DEPTH       = 256,
    parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    wb_slave_mem_if.slave wb
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_accept;
    logic        w_enter_resp;

    logic [31:0] r_adr;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_wdat;

    logic        r_ack;
    logic        r_err;
    logic [31:0] r_dat;

    logic [31:0] r_mem [DEPTH];

    logic [31:0] w_adr;
    logic        w_we;
    logic [3:0]  w_sel;
    logic [31:0] w_wdat;
    logic [32:0] w_off;
    logic        w_in_range;
    logic [AW-1:0] w_idx;

    // With no wait states the response is decided on the acceptance edge,
    // so the live bus fields are used before they are latched.
    always_comb begin
        w_adr  = r_adr;
        w_we   = r_we;
        w_sel  = r_sel;
        w_wdat = r_wdat;
        if (r_state == IDLE) begin
            w_adr  = wb.wb_adr_i;
            w_we   = wb.wb_we_i;
            w_sel  = wb.wb_sel_i;
            w_wdat = wb.wb_dat_i;
        end
        w_off      = {1'b0, w_adr} - {1'b0, BASE_ADR};
        w_in_range = !w_off[32] && (w_off < SPAN);
        w_idx      = w_off[AW+1:2];
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (wb.wb_cyc_i && wb.wb_stb_i) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt  = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (!wb.wb_cyc_i) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt  = RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= 32'd0;
            r_adr   <= 32'd0;
            r_we    <= 1'b0;
            r_sel   <= 4'd0;
            r_wdat  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_enter_resp && w_in_range;
            r_err   <= w_enter_resp && !w_in_range;
            r_dat   <= (w_enter_resp && w_in_range && !w_we) ? r_mem[w_idx] : 32'd0;
            if (w_accept) begin
                r_adr  <= wb.wb_adr_i;
                r_we   <= wb.wb_we_i;
                r_sel  <= wb.wb_sel_i;
                r_wdat <= wb.wb_dat_i;
            end
        end
    end

    // Contents survive reset; only the commit itself is suppressed by it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i && w_enter_resp && w_in_range && w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_sel[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
                end
            end
        end
    end

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_err_o = r_err;
    assign wb.wb_dat_o = r_dat;
endmodule

// File: tb/tb_wb_slave_mem.sv
// Bench for wb_slave_mem: one instance with no wait states, one with three,
// checked every cycle against a transaction-level memory model.
module tb_wb_slave_mem;
    logic clk = 1'b0;
    logic rst0_n = 1'b0;
    logic rst3_n = 1'b0;
    always #5 clk = ~clk;

    wb_slave_mem_if if0 ();
    wb_slave_mem_if if3 ();

    wb_slave_mem #(.DEPTH(256), .BASE_ADR(32'h0), .WAIT_CYCLES(0)) dut0 (
        .wb_clk_i (clk),
        .wb_rst_i (rst0_n),
        .wb       (if0.slave)
    );

    wb_slave_mem #(.DEPTH(256), .BASE_ADR(32'h0), .WAIT_CYCLES(3)) dut3 (
        .wb_clk_i (clk),
        .wb_rst_i (rst3_n),
        .wb       (if3.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc_cnt = 0;
    bit cmp_en = 1'b0;

    // Model state, index 0 = no-wait instance, index 1 = three-wait instance.
    logic [31:0] mmem   [2][256];
    bit          mknown [2][256];
    bit          exp_ack [2];
    bit          exp_err [2];
    bit          chk_dat [2];
    logic [31:0] exp_dat [2];
    int          resp_cnt [2];
    int          last_resp [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic get_ack(input int d);
        return (d == 0) ? if0.wb_ack_o : if3.wb_ack_o;
    endfunction
    function automatic logic get_err(input int d);
        return (d == 0) ? if0.wb_err_o : if3.wb_err_o;
    endfunction
    function automatic logic [31:0] get_dat(input int d);
        return (d == 0) ? if0.wb_dat_o : if3.wb_dat_o;
    endfunction

    task automatic drive(input int d, input bit cyc, input bit stb, input bit we,
                         input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        if (d == 0) begin
            if0.wb_cyc_i = cyc; if0.wb_stb_i = stb; if0.wb_we_i = we;
            if0.wb_sel_i = sel; if0.wb_adr_i = adr; if0.wb_dat_i = dat;
        end else begin
            if3.wb_cyc_i = cyc; if3.wb_stb_i = stb; if3.wb_we_i = we;
            if3.wb_sel_i = sel; if3.wb_adr_i = adr; if3.wb_dat_i = dat;
        end
    endtask

    always @(posedge clk) cyc_cnt++;

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("ack%0d", d), 32'(get_ack(d)), 32'(exp_ack[d]));
                check($sformatf("err%0d", d), 32'(get_err(d)), 32'(exp_err[d]));
                if (!exp_ack[d] || chk_dat[d])
                    check($sformatf("dat%0d", d), get_dat(d), exp_ack[d] ? exp_dat[d] : 32'd0);
                if (get_ack(d) || get_err(d)) begin
                    resp_cnt[d]++;
                    last_resp[d] = cyc_cnt;
                end
            end
        end
    end

    // Full transfer: stb is dropped right after acceptance while cyc is held.
    task automatic xfer(input int d, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, output logic [31:0] rd);
        int w;
        int acc;
        int r0;
        bit inr;
        logic [7:0] idx;
        w = (d == 0) ? 0 : 3;
        @(posedge clk); #1;
        drive(d, 1, 1, we, sel, adr, dat);
        @(posedge clk); #1;
        acc = cyc_cnt;
        r0  = resp_cnt[d];
        drive(d, 1, 0, we, sel, adr, dat);
        repeat (w) begin @(posedge clk); #1; end
        inr = (adr < 32'h400);
        idx = adr[9:2];
        exp_ack[d] = inr;
        exp_err[d] = !inr;
        if (inr && !we) begin
            exp_dat[d] = mmem[d][idx];
            chk_dat[d] = mknown[d][idx];
        end
        if (inr && we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) mmem[d][idx][8*b +: 8] = dat[8*b +: 8];
            if (sel == 4'hF) mknown[d][idx] = 1'b1;
        end
        rd = get_dat(d);
        drive(d, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        exp_ack[d] = 1'b0;
        exp_err[d] = 1'b0;
        chk_dat[d] = 1'b0;
        exp_dat[d] = 32'd0;
        check($sformatf("latency%0d", d), 32'(last_resp[d] - acc + 1), 32'(w + 1));
        check($sformatf("one_resp%0d", d), 32'(resp_cnt[d] - r0), 32'd1);
    endtask

    task automatic xfer_abort(input logic [31:0] adr, input logic [31:0] dat);
        int r0;
        r0 = resp_cnt[1];
        @(posedge clk); #1;
        drive(1, 1, 1, 1, 4'hF, adr, dat);
        @(posedge clk); #1;
        drive(1, 1, 0, 1, 4'hF, adr, dat);
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        repeat (6) begin @(posedge clk); #1; end
        check("abort_no_resp", 32'(resp_cnt[1] - r0), 32'd0);
    endtask

    task automatic xfer_reset(input logic [31:0] adr, input logic [31:0] dat);
        int r0;
        r0 = resp_cnt[1];
        @(posedge clk); #1;
        drive(1, 1, 1, 1, 4'hF, adr, dat);
        @(posedge clk); #1;
        drive(1, 1, 0, 1, 4'hF, adr, dat);
        rst3_n = 1'b0;
        @(posedge clk); #1;
        rst3_n = 1'b1;
        drive(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        repeat (6) begin @(posedge clk); #1; end
        check("reset_no_resp", 32'(resp_cnt[1] - r0), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        for (int d = 0; d < 2; d++) begin
            exp_ack[d] = 0; exp_err[d] = 0; chk_dat[d] = 0; exp_dat[d] = 0;
            resp_cnt[d] = 0; last_resp[d] = 0;
            for (int i = 0; i < 256; i++) begin
                mmem[d][i] = 32'h0; mknown[d][i] = 1'b0;
            end
        end
        drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        drive(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst0_n = 1'b1;
        rst3_n = 1'b1;

        // No wait states: full-word and partial-lane writes.
        xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
        xfer(0, 0, 32'h10, 32'h0, 4'hF, rd);
        check("rd_deadbeef", rd, 32'hDEADBEEF);
        xfer(0, 1, 32'h10, 32'h11223344, 4'b0101, rd);
        xfer(0, 0, 32'h10, 32'h0, 4'b0001, rd);
        check("rd_lanes", rd, 32'hDE22BE44);

        // Range boundaries and error terminations.
        xfer(0, 1, 32'h3FC, 32'h55AA55AA, 4'hF, rd);
        xfer(0, 1, 32'h0, 32'h01020304, 4'hF, rd);
        xfer(0, 0, 32'h400, 32'h0, 4'hF, rd);
        xfer(0, 1, 32'hFFFFFFFC, 32'hFFFFFFFF, 4'hF, rd);
        xfer(0, 1, 32'h3FC, 32'h12345678, 4'h0, rd);
        xfer(0, 0, 32'h3FC, 32'h0, 4'hF, rd);
        check("rd_last_word", rd, 32'h55AA55AA);
        xfer(0, 0, 32'h0, 32'h0, 4'hF, rd);
        check("rd_word0", rd, 32'h01020304);
        xfer(0, 0, 32'h10, 32'h0, 4'hF, rd);
        check("rd_0x10_after_err", rd, 32'hDE22BE44);

        // Three wait states, abort and mid-transfer reset.
        xfer(1, 1, 32'h0, 32'hA5A5A5A5, 4'hF, rd);
        xfer(1, 0, 32'h0, 32'h0, 4'hF, rd);
        check("rd_wait3", rd, 32'hA5A5A5A5);
        xfer(1, 1, 32'h20, 32'h12345678, 4'hF, rd);
        xfer_abort(32'h20, 32'hCAFE0000);
        xfer(1, 0, 32'h20, 32'h0, 4'hF, rd);
        check("rd_after_abort", rd, 32'h12345678);
        xfer(1, 1, 32'h24, 32'h0BADF00D, 4'hF, rd);
        xfer_reset(32'h24, 32'hFFFFFFFF);
        xfer(1, 0, 32'h24, 32'h0, 4'hF, rd);
        check("rd_after_reset", rd, 32'h0BADF00D);
        xfer(1, 0, 32'h404, 32'h0, 4'hF, rd);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/wb_slave_mem.md
WB_SLAVE_MEM -- requirements
Module: wb_slave_mem

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning number of 32-bit words (power of two, 2..65536).
REQ-002 The block SHALL have parameter BASE_ADR, default 32'h0000_0000, meaning byte address of word 0 (DEPTH*4-aligned).
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 0, meaning extra wait states before each response (0..15).
REQ-004 The block SHALL have port wb_clk_i  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port wb_rst_i  input  1  meaning reset, synchronous, active-low.
REQ-006 The block SHALL have port wb_cyc_i  input  1  meaning bus cycle valid.
REQ-007 The block SHALL have port wb_stb_i  input  1  meaning strobe, transfer request.
REQ-008 The block SHALL have port wb_we_i  input  1  meaning 1 = write, 0 = read.
REQ-009 The block SHALL have port wb_sel_i  input  4  meaning byte lane enables; bit n covers dat[8n+7:8n].
REQ-010 The block SHALL have port wb_adr_i  input  32  meaning byte address; bits [1:0] ignored.
REQ-011 The block SHALL have port wb_dat_i  input  32  meaning write data.
REQ-012 The block SHALL have port wb_dat_o  output  32  meaning read data, valid only while wb_ack_o = 1.
REQ-013 The block SHALL have port wb_ack_o  output  1  meaning normal termination, registered.
REQ-014 The block SHALL have port wb_err_o  output  1  meaning error termination, registered.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP; IDLE is the reset state.
REQ-016 A request SHALL be accepted on a rising edge in IDLE where wb_cyc_i & wb_stb_i = 1; the block latches adr, we, sel, dat at that edge.
REQ-017 On acceptance, WAIT_CYCLES = 0 SHALL go directly to RESP; otherwise WAIT is entered and a 4-bit counter loaded with WAIT_CYCLES-1.
REQ-018 In WAIT, the counter SHALL decrement each edge; the FSM goes to RESP on the edge where the counter is 0.
REQ-019 Acceptance-to-ack latency SHALL be exactly 1 + WAIT_CYCLES clock cycles; ack/err is high for exactly one cycle (RESP), then IDLE.
REQ-020 Exactly one of wb_ack_o or wb_err_o SHALL assert per accepted request, never both.
REQ-021 wb_err_o SHALL assert when the latched address is outside [BASE_ADR, BASE_ADR + 4*DEPTH); memory is untouched and wb_dat_o = 0.
REQ-022 Writes SHALL update only lanes with sel bit = 1, at the edge entering RESP; sel = 4'b0000 still acks with no change.
REQ-023 Reads SHALL present the full 32-bit word on wb_dat_o during RESP regardless of sel; wb_dat_o SHALL be 0 whenever wb_ack_o = 0.
REQ-024 No new request SHALL be accepted in WAIT or RESP; a request still asserted in the cycle after RESP (IDLE) is accepted as a new transfer.
REQ-025 If wb_cyc_i drops during WAIT, the FSM SHALL return to IDLE next edge: no ack, no err, no memory write (abort).
REQ-026 wb_stb_i deasserting while wb_cyc_i stays high during WAIT SHALL NOT abort the transfer.
REQ-027 Word index SHALL be (adr - BASE_ADR) >> 2, truncated to log2(DEPTH) bits after the range check.

Reset
REQ-028 While wb_rst_i = 0 at a rising edge, the FSM SHALL go to IDLE, counter = 0, wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0.
REQ-029 Reset mid-transfer (WAIT or RESP) SHALL drop any pending response; a write not yet committed SHALL NOT reach memory.
REQ-030 Memory contents SHALL NOT be cleared by reset; reads before any write return undefined data.

Verification
REQ-031 Write 32'hDEADBEEF to 0x10, sel=4'hF, WAIT_CYCLES=0, then read 0x10 -> each ack 1 cycle after acceptance, read data 32'hDEADBEEF.
REQ-032 After REQ-031, write 32'h11223344 to 0x10 with sel=4'b0101, read 0x10 -> 32'hDE22BE44.
REQ-033 WAIT_CYCLES=3: read 0x0 -> ack exactly 4 cycles after acceptance, wb_dat_o = 0 in all other cycles.
REQ-034 DEPTH=256, BASE_ADR=0: read 0x400 and write 0xFFFFFFFC -> wb_err_o one cycle each, wb_ack_o = 0, memory at 0x0..0x3FC unchanged.
REQ-035 WAIT_CYCLES=3: write 32'hCAFE0000 to 0x20, drop wb_cyc_i after 1 wait cycle -> no ack/err; subsequent read 0x20 returns prior contents.
REQ-036 Assert wb_rst_i = 0 for one edge during WAIT of a write to 0x24 -> ack/err never assert, next read of 0x24 returns prior contents, FSM accepts the following request normally.
